// File: rtl/tile_grid_mapper.sv
// Tile grid mapper: turns a screen pixel position into a tile lookup
// (tile type plus the pixel offset inside that tile). It also keeps the
// level map and handles one-at-a-time tile clear requests, which are
// applied on the next start-of-frame pulse.
module tile_grid_mapper #(
  parameter int TILE_W = 80,
  parameter int TILE_H = 80,
  parameter int COLS   = 8,
  parameter int ROWS   = 6
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        clearReq,
  input  logic [3:0]  clearCol,
  input  logic [2:0]  clearRow,
  output logic        busy,
  output logic        clearAck,
  output logic        clearHit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [1:0]  Tile_type,
  output logic        insideGrid
);

  localparam logic [1:0] T_BG    = 2'b00;
  localparam logic [1:0] T_FLOOR = 2'b01;
  localparam logic [1:0] T_GIFT  = 2'b10;
  localparam logic [1:0] T_HOLE  = 2'b11;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  localparam int GRID_W = COLS * TILE_W;
  localparam int GRID_H = ROWS * TILE_H;

  // Initial level contents; the hole overrides the floor row it sits in.
  function automatic logic [1:0] level_entry(input int r, input int c);
    if (r == 5 && c == 6)                    return T_HOLE;
    else if (r == 5)                         return T_FLOOR;
    else if (r == 3 && c >= 2 && c <= 5)     return T_FLOOR;
    else if (r == 2 && c == 3)               return T_GIFT;
    else                                     return T_BG;
  endfunction

  logic [1:0]  map_q [ROWS][COLS];
  logic [1:0]  map_d [ROWS][COLS];

  logic        state_q, state_d;
  logic [3:0]  cap_col_q, cap_col_d;
  logic [2:0]  cap_row_q, cap_row_d;
  logic        ack_q, ack_d;
  logic        hit_q, hit_d;

  logic [10:0] off_x_q, off_x_d;
  logic [10:0] off_y_q, off_y_d;
  logic [1:0]  type_q, type_d;
  logic        inside_q, inside_d;

  int          col_idx;
  int          row_idx;

  // Pixel lookup: comparator chain for tile column/row, then map read and offsets.
  always_comb begin
    col_idx  = 0;
    row_idx  = 0;
    type_d   = T_BG;
    off_x_d  = '0;
    off_y_d  = '0;
    inside_d = 1'b0;
    for (int c = 1; c < COLS; c++) begin
      if (int'(pixelX) >= c * TILE_W) col_idx = c;
    end
    for (int r = 1; r < ROWS; r++) begin
      if (int'(pixelY) >= r * TILE_H) row_idx = r;
    end
    if (int'(pixelX) < GRID_W && int'(pixelY) < GRID_H) begin
      inside_d = 1'b1;
      off_x_d  = pixelX - 11'(col_idx * TILE_W);
      off_y_d  = pixelY - 11'(row_idx * TILE_H);
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (r == row_idx && c == col_idx) type_d = map_q[r][c];
        end
      end
    end
  end

  // Clear handling: capture a request when idle, apply it on the next frame start.
  always_comb begin
    state_d   = state_q;
    cap_col_d = cap_col_q;
    cap_row_d = cap_row_q;
    ack_d     = 1'b0;
    hit_d     = 1'b0;
    map_d     = map_q;
    case (state_q)
      ST_IDLE: begin
        if (clearReq) begin
          cap_col_d = clearCol;
          cap_row_d = clearRow;
          state_d   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (startOfFrame) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (r == int'(cap_row_q) && c == int'(cap_col_q) && map_q[r][c] == T_GIFT) begin
                hit_d       = 1'b1;
                map_d[r][c] = T_BG;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lookup output registers, one cycle behind the pixel inputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      off_x_q  <= '0;
      off_y_q  <= '0;
      type_q   <= T_BG;
      inside_q <= 1'b0;
    end else begin
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      type_q   <= type_d;
      inside_q <= inside_d;
    end
  end

  // Clear state and map storage; reset reloads the starting level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      cap_col_q <= '0;
      cap_row_q <= '0;
      ack_q     <= 1'b0;
      hit_q     <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          map_q[r][c] <= level_entry(r, c);
        end
      end
    end else begin
      state_q   <= state_d;
      cap_col_q <= cap_col_d;
      cap_row_q <= cap_row_d;
      ack_q     <= ack_d;
      hit_q     <= hit_d;
      map_q     <= map_d;
    end
  end

  assign busy       = (state_q == ST_PENDING);
  assign clearAck   = ack_q;
  assign clearHit   = hit_q;
  assign offsetX    = off_x_q;
  assign offsetY    = off_y_q;
  assign Tile_type  = type_q;
  assign insideGrid = inside_q;

endmodule

// File: tb/tb_tile_grid_mapper.sv
// Self-checking bench for tile_grid_mapper: a division-based reference
// model of the grid and clear behaviour is compared every cycle, plus
// literal expectations for the known lookup and clear scenarios.
module tb_tile_grid_mapper;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        clearReq = 1'b0;
  logic [3:0]  clearCol = '0;
  logic [2:0]  clearRow = '0;
  logic        busy, clearAck, clearHit, insideGrid;
  logic [10:0] offsetX, offsetY;
  logic [1:0]  Tile_type;

  int totalChecks = 0;
  int passedChecks = 0;
  logic chkEn = 1'b0;

  tile_grid_mapper dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .clearReq(clearReq), .clearCol(clearCol),
    .clearRow(clearRow), .busy(busy), .clearAck(clearAck), .clearHit(clearHit),
    .offsetX(offsetX), .offsetY(offsetY), .Tile_type(Tile_type), .insideGrid(insideGrid)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0]  mmap [6][8];
  logic        mPending;
  int          mCapCol, mCapRow;
  int          mpx, mpy;
  logic [1:0]  expType;
  logic [10:0] expOffX, expOffY;
  logic        expInside, expBusy, expAck, expHit;

  task automatic loadLevel();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        mmap[r][c] = 2'b00;
    for (int c = 0; c < 8; c++) mmap[5][c] = 2'b01;
    for (int c = 2; c <= 5; c++) mmap[3][c] = 2'b01;
    mmap[2][3] = 2'b10;
    mmap[5][6] = 2'b11;
  endtask

  // Model: what the registered outputs must be after each edge
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      loadLevel();
      mPending = 1'b0; mCapCol = 0; mCapRow = 0;
      expType = 2'b00; expOffX = '0; expOffY = '0; expInside = 1'b0;
      expBusy = 1'b0; expAck = 1'b0; expHit = 1'b0;
    end else begin
      mpx = int'(pixelX);
      mpy = int'(pixelY);
      if (mpx < 640 && mpy < 480) begin
        expInside = 1'b1;
        expType   = mmap[mpy / 80][mpx / 80];
        expOffX   = 11'(mpx % 80);
        expOffY   = 11'(mpy % 80);
      end else begin
        expInside = 1'b0; expType = 2'b00; expOffX = '0; expOffY = '0;
      end
      expAck = 1'b0;
      expHit = 1'b0;
      if (mPending) begin
        if (startOfFrame) begin
          expAck = 1'b1;
          if (mCapCol < 8 && mCapRow < 6 && mmap[mCapRow][mCapCol] == 2'b10) begin
            expHit = 1'b1;
            mmap[mCapRow][mCapCol] = 2'b00;
          end
          mPending = 1'b0;
        end
      end else if (clearReq) begin
        mPending = 1'b1;
        mCapCol  = int'(clearCol);
        mCapRow  = int'(clearRow);
      end
      expBusy = mPending;
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chkEn) begin
      totalChecks++;
      if ({Tile_type, insideGrid, offsetX, offsetY} !== {expType, expInside, expOffX, expOffY})
        $display("[TB] FAIL lookup t=%0t: got type=%b in=%b ox=%0d oy=%0d, required type=%b in=%b ox=%0d oy=%0d",
                 $time, Tile_type, insideGrid, offsetX, offsetY, expType, expInside, expOffX, expOffY);
      else
        passedChecks++;
      totalChecks++;
      if (busy !== expBusy || clearAck !== expAck || (expAck && clearHit !== expHit))
        $display("[TB] FAIL control t=%0t: got busy=%b ack=%b hit=%b, required busy=%b ack=%b hit=%b",
                 $time, busy, clearAck, clearHit, expBusy, expAck, expHit);
      else
        passedChecks++;
    end
  end

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] req);
    totalChecks++;
    if (act !== req)
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    else
      passedChecks++;
  endtask

  task automatic applyStimulus(input int px, input int py);
    @(negedge clk);
    pixelX = 11'(px);
    pixelY = 11'(py);
  endtask

  task automatic lookupCheck(input string name, input int px, input int py,
                             input logic [1:0] t, input int ox, input int oy, input logic ins);
    applyStimulus(px, py);
    @(negedge clk);
    checkOutput({name, ".type"}, 11'(Tile_type), 11'(t));
    checkOutput({name, ".offX"}, offsetX, 11'(ox));
    checkOutput({name, ".offY"}, offsetY, 11'(oy));
    checkOutput({name, ".inside"}, 11'(insideGrid), 11'(ins));
  endtask

  task automatic sendClear(input int col, input int row, input logic withSof);
    @(negedge clk);
    clearReq = 1'b1; clearCol = 4'(col); clearRow = 3'(row); startOfFrame = withSof;
    @(negedge clk);
    clearReq = 1'b0; startOfFrame = 1'b0;
  endtask

  task automatic pulseSof(input string name, input logic ackReq, input logic hitReq);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    checkOutput({name, ".ack"}, 11'(clearAck), 11'(ackReq));
    checkOutput({name, ".busy"}, 11'(busy), 11'(0));
    if (ackReq) checkOutput({name, ".hit"}, 11'(clearHit), 11'(hitReq));
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 resetN = 1'b0;
    chkEn = 1'b1;
    #1;
    checkOutput("reset.busy", 11'(busy), 11'(0));
    checkOutput("reset.ack", 11'(clearAck), 11'(0));
    checkOutput("reset.inside", 11'(insideGrid), 11'(0));
    checkOutput("reset.type", 11'(Tile_type), 11'(0));
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Known lookups, including grid edge and just outside
    lookupCheck("gift", 250, 205, 2'b10, 10, 45, 1'b1);
    lookupCheck("corner", 639, 479, 2'b01, 79, 79, 1'b1);
    lookupCheck("outX", 640, 10, 2'b00, 0, 0, 1'b0);
    lookupCheck("outY", 10, 480, 2'b00, 0, 0, 1'b0);
    lookupCheck("hole", 500, 420, 2'b11, 20, 20, 1'b1);
    lookupCheck("origin", 0, 0, 2'b00, 0, 0, 1'b1);

    // Clear the gift after a long wait for frame start
    sendClear(3, 2, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 0) checkOutput("wait.busy", 11'(busy), 11'(1));
    end
    pulseSof("giftClear", 1'b1, 1'b1);
    lookupCheck("giftGone", 250, 205, 2'b00, 10, 45, 1'b1);

    // Hole and out-of-range clears are acked without a hit
    sendClear(6, 5, 1'b0);
    pulseSof("holeClear", 1'b1, 1'b0);
    sendClear(9, 0, 1'b0);
    pulseSof("rangeClear", 1'b1, 1'b0);
    lookupCheck("holeKept", 500, 420, 2'b11, 20, 20, 1'b1);

    // Capture together with frame start waits for the next pulse; extra request ignored
    sendClear(0, 5, 1'b1);
    checkOutput("sameSof.ack", 11'(clearAck), 11'(0));
    checkOutput("sameSof.busy", 11'(busy), 11'(1));
    sendClear(1, 5, 1'b0);
    pulseSof("nextSof", 1'b1, 1'b0);
    pulseSof("noExtra", 1'b0, 1'b0);

    // Reset in the middle of a pending clear restores the level
    sendClear(4, 4, 1'b0);
    repeat (3) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midReset.busy", 11'(busy), 11'(0));
    checkOutput("midReset.ack", 11'(clearAck), 11'(0));
    @(negedge clk);
    resetN = 1'b1;
    pulseSof("afterReset", 1'b0, 1'b0);
    lookupCheck("giftBack", 250, 205, 2'b10, 10, 45, 1'b1);

    // Randomized traffic, model comparison every cycle
    for (int i = 0; i < 2500; i++) begin
      if (i == 1250) doReset();
      @(negedge clk);
      pixelX = 11'($urandom_range(0, 700));
      pixelY = 11'($urandom_range(0, 520));
      clearReq = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        clearCol = 4'd3; clearRow = 3'd2;
      end else begin
        clearCol = 4'($urandom_range(0, 15));
        clearRow = 3'($urandom_range(0, 7));
      end
      startOfFrame = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    clearReq = 1'b0; startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
    chkEn = 1'b0;

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
